// File: rtl/wb_firmware_loader_if.sv
// Wishbone write-master bundle between the firmware loader and the RAM.
// Signals:
//   adr  - byte address of the word being written
//   dat  - 32-bit write data
//   sel  - byte-lane selects
//   we   - write enable
//   cyc  - bus cycle in progress
//   stb  - strobe
//   ack  - slave acknowledge
//   err  - slave error termination
interface wb_firmware_loader_if;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        err;

  modport master (output adr, dat, sel, we, cyc, stb, input ack, err);
  modport slave  (input adr, dat, sel, we, cyc, stb, output ack, err);
endinterface

// File: rtl/wb_firmware_loader.sv
// Byte-stream firmware loader. Packs incoming bytes big-endian into 32-bit
// words and writes them to a Wishbone RAM starting at BASE_ADDR. The first
// word of the image is its total size in bytes (header included).
// Ports:
//   clk_i, rst_i         - clock, synchronous active-high reset
//   start_i              - one-cycle pulse that arms a new load
//   rx_data_i/rx_valid_i - incoming byte stream
//   rx_ready_o           - byte accepted on edges where valid && ready
//   wb                   - Wishbone master (single write cycles)
//   busy_o/done_o/error_o - load status
//
// state | meaning
// IDLE  | waiting for start_i
// HDR   | collecting the 4 header (size) bytes
// DATA  | collecting the 4 bytes of the next word
// WRITE | Wishbone write cycle in flight
// DONE  | whole image written
// ERROR | bad header or bus error, load aborted
module wb_firmware_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_SIZE  = 8192
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [7:0]                    rx_data_i,
  input  logic                          rx_valid_i,
  output logic                          rx_ready_o,
  wb_firmware_loader_if.master          wb,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          error_o
);

  localparam logic [31:0] MAX_SIZE_W = 32'(MAX_SIZE);

  typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, DONE, ERROR} state_t;

  state_t      r_state;
  logic [31:0] r_shift;
  logic [1:0]  r_byte_cnt;
  logic [31:0] r_size;
  logic [31:0] r_written;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic [3:0]  r_sel;
  logic        r_cyc;
  logic        r_ready;
  logic        r_busy;
  logic        r_done;
  logic        r_error;

  logic        w_accept;
  logic [31:0] w_word;
  logic        w_size_ok;
  logic [31:0] w_written_nxt;

  assign w_accept      = rx_valid_i && r_ready;
  // Shifting in from the LSB end leaves byte 0 in the MSB after four bytes.
  assign w_word        = {r_shift[23:0], rx_data_i};
  assign w_size_ok     = (w_word != 32'd0) && (w_word[1:0] == 2'b00) &&
                         (w_word <= MAX_SIZE_W);
  assign w_written_nxt = r_written + 32'd4;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_byte_cnt <= '0;
      r_size     <= '0;
      r_written  <= '0;
      r_adr      <= '0;
      r_dat      <= '0;
      r_sel      <= '0;
      r_cyc      <= 1'b0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE, ERROR: begin
          if (start_i) begin
            r_state    <= HDR;
            r_byte_cnt <= '0;
            r_written  <= '0;
            r_adr      <= BASE_ADDR;
            r_ready    <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
          end
        end
        HDR: begin
          if (w_accept) begin
            r_shift    <= w_word;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_ready <= 1'b0;
              if (w_size_ok) begin
                // The header itself is the first word of the image.
                r_size  <= w_word;
                r_dat   <= w_word;
                r_cyc   <= 1'b1;
                r_sel   <= 4'hF;
                r_state <= WRITE;
              end else begin
                r_busy  <= 1'b0;
                r_error <= 1'b1;
                r_state <= ERROR;
              end
            end
          end
        end
        DATA: begin
          if (w_accept) begin
            r_shift    <= w_word;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_ready <= 1'b0;
              r_dat   <= w_word;
              r_cyc   <= 1'b1;
              r_sel   <= 4'hF;
              r_state <= WRITE;
            end
          end
        end
        WRITE: begin
          // Error termination takes priority over a simultaneous ack.
          if (wb.err) begin
            r_cyc   <= 1'b0;
            r_sel   <= 4'h0;
            r_busy  <= 1'b0;
            r_error <= 1'b1;
            r_state <= ERROR;
          end else if (wb.ack) begin
            r_cyc     <= 1'b0;
            r_sel     <= 4'h0;
            r_adr     <= r_adr + 32'd4;
            r_written <= w_written_nxt;
            if (w_written_nxt == r_size) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_ready <= 1'b1;
              r_state <= DATA;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rx_ready_o = r_ready;
  assign wb.adr     = r_adr;
  assign wb.dat     = r_dat;
  assign wb.sel     = r_sel;
  assign wb.we      = r_cyc;
  assign wb.cyc     = r_cyc;
  assign wb.stb     = r_cyc;
  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign error_o    = r_error;

endmodule

// File: tb/tb_wb_firmware_loader.sv
module tb_wb_firmware_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic       busy, done, error;

  wb_firmware_loader_if wb ();

  wb_firmware_loader #(.BASE_ADDR(32'h0000_0000), .MAX_SIZE(8192)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .rx_data_i (rx_data),
    .rx_valid_i(rx_valid),
    .rx_ready_o(rx_ready),
    .wb        (wb),
    .busy_o    (busy),
    .done_o    (done),
    .error_o   (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- Wishbone RAM slave model ----------------
  logic [31:0] mem [0:63];
  int          wr_count   = 0;
  int          cyc_starts = 0;
  int          sel_bad    = 0;
  int          overlap    = 0;
  int          wr_base    = 0;
  int          err_at     = -1;
  int          fixed_wait = 0;
  bit          rand_mode  = 1'b0;
  bit          clr_mem    = 1'b0;
  int          wcnt       = 0;
  int          rand_wait  = 0;
  logic        cyc_q      = 1'b0;
  int          need;

  assign need   = rand_mode ? rand_wait : fixed_wait;
  assign wb.err = wb.cyc && wb.stb && ((wr_count - wr_base) == err_at);
  assign wb.ack = wb.cyc && wb.stb && (wcnt == need) && !wb.err;

  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0BAD_0BAD;
    end
    if (wb.ack) begin
      mem[wb.adr[7:2]] <= wb.dat;
      wr_count  <= wr_count + 1;
      if (wb.sel !== 4'hF || wb.we !== 1'b1) sel_bad <= sel_bad + 1;
      wcnt      <= 0;
      rand_wait <= int'($urandom_range(0, 3));
    end else if (wb.cyc && wb.stb) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
    end
    if (wb.cyc && !cyc_q) cyc_starts <= cyc_starts + 1;
    cyc_q <= wb.cyc;
    if (rx_ready && wb.cyc) overlap <= overlap + 1;
  end

  // ---------------- stimulus helpers (start/end on negedge) ----------------
  logic [31:0] img [0:15];

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_ram();
    clr_mem = 1'b1;
    @(negedge clk);
    clr_mem = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("rx_ready_timeout", 32'(n), 32'd0);
    @(negedge clk);
    rx_valid = 1'b0;
    if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
  endtask

  task automatic send_img(input int first, input int nbytes, input int max_gap);
    logic [31:0] w;
    for (int i = first; i < first + nbytes; i++) begin
      w = img[i / 4];
      send_byte(w[31 - 8 * (i % 4) -: 8], max_gap);
    end
  endtask

  task automatic wait_end();
    int n = 0;
    while (!done && !error && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("end_timeout", 32'(n), 32'd0);
  endtask

  logic [31:0] bad_hdr [0:2];

  initial begin
    bad_hdr[0] = 32'h0000_000A;
    bad_hdr[1] = 32'h0000_0000;
    bad_hdr[2] = 32'h0000_2004;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outs", {26'd0, wb.cyc, rx_ready, busy, done, error, wb.sel != 4'h0}, 32'd0);

    // ---- basic 12-byte image, one wait state ----
    clear_ram();
    fixed_wait = 1;
    wr_base = wr_count;
    img[0] = 32'h0000_000C; img[1] = 32'hDEAD_BEEF; img[2] = 32'h0102_0304;
    pulse_start();
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    send_img(0, 12, 0);
    wait_end();
    chk("t1_w0", mem[0], 32'h0000_000C);
    chk("t1_w1", mem[1], 32'hDEAD_BEEF);
    chk("t1_w2", mem[2], 32'h0102_0304);
    chk("t1_status", {29'd0, done, busy, error}, 32'h4);
    chk("t1_writes", 32'(wr_count - wr_base), 32'd3);
    chk("t1_sel", 32'(sel_bad), 32'd0);

    // ---- invalid headers ----
    for (int h = 0; h < 3; h++) begin
      int cs;
      cs = cyc_starts;
      img[0] = bad_hdr[h];
      pulse_start();
      send_img(0, 4, 0);
      chk($sformatf("bad_hdr%0d_err", h), {30'd0, error, busy}, 32'h2);
      repeat (2) @(negedge clk);
      chk($sformatf("bad_hdr%0d_nocyc", h), 32'(cyc_starts - cs), 32'd0);
      chk($sformatf("bad_hdr%0d_rdy", h), {31'd0, rx_ready}, 32'd0);
    end

    // ---- bus error on second write, then clean reload ----
    clear_ram();
    fixed_wait = 0;
    img[0] = 32'h0000_0010; img[1] = 32'h1122_3344;
    img[2] = 32'h5566_7788; img[3] = 32'h99AA_BBCC;
    wr_base = wr_count;
    err_at = 1;
    pulse_start();
    send_img(0, 8, 0);
    wait_end();
    chk("err_flag", {31'd0, error}, 32'd1);
    chk("err_cyc_low", {31'd0, wb.cyc}, 32'd0);
    repeat (6) @(negedge clk);
    chk("err_writes", 32'(wr_count - wr_base), 32'd1);
    chk("err_rdy", {31'd0, rx_ready}, 32'd0);
    err_at = -1;
    wr_base = wr_count;
    pulse_start();
    chk("reload_clears_err", {31'd0, error}, 32'd0);
    send_img(0, 16, 0);
    wait_end();
    chk("reload_done", {30'd0, done, error}, 32'h2);
    chk("reload_w1", mem[1], 32'h1122_3344);
    chk("reload_w3", mem[3], 32'h99AA_BBCC);

    // ---- 64-byte image, random byte gaps and ack delays ----
    clear_ram();
    rand_mode = 1'b1;
    img[0] = 32'h0000_0040;
    for (int i = 1; i < 16; i++) img[i] = 32'(i) * 32'h1010_1011 ^ 32'hA5A5_0000;
    wr_base = wr_count;
    begin
      int ov;
      ov = overlap;
      pulse_start();
      send_img(0, 64, 2);
      wait_end();
      chk("rand_done", {31'd0, done}, 32'd1);
      chk("rand_writes", 32'(wr_count - wr_base), 32'd16);
      chk("rand_overlap", 32'(overlap - ov), 32'd0);
    end
    for (int i = 0; i < 16; i++) chk($sformatf("rand_w%0d", i), mem[i], img[i]);
    rand_mode = 1'b0;

    // ---- reset during third write ----
    fixed_wait = 3;
    img[0] = 32'h0000_0010; img[1] = 32'h1111_1111;
    img[2] = 32'h2222_2222; img[3] = 32'h3333_3333;
    wr_base = wr_count;
    pulse_start();
    send_img(0, 12, 0);
    begin
      int n = 0;
      while (!((wr_count - wr_base) == 2 && wb.cyc) && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("third_write_seen", 32'(n < 200), 32'd1);
    end
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rst_outs", {25'd0, wb.cyc, wb.stb, wb.we, rx_ready, busy, done, error}, 32'd0);
    chk("rst_sel", {28'd0, wb.sel}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_start_ignored", {31'd0, busy}, 32'd0);
    clear_ram();
    fixed_wait = 0;
    img[0] = 32'h0000_0008; img[1] = 32'hCAFE_BABE;
    pulse_start();
    send_img(0, 8, 0);
    wait_end();
    chk("post_rst_done", {31'd0, done}, 32'd1);
    chk("post_rst_w0", mem[0], 32'h0000_0008);
    chk("post_rst_w1", mem[1], 32'hCAFE_BABE);

    // ---- start pulse during DATA is ignored ----
    clear_ram();
    img[0] = 32'h0000_000C; img[1] = 32'hFEED_F00D; img[2] = 32'h0BAD_CAFE;
    wr_base = wr_count;
    pulse_start();
    send_img(0, 6, 0);
    pulse_start();
    chk("start_in_data_busy", {31'd0, busy}, 32'd1);
    send_img(6, 6, 0);
    wait_end();
    chk("start_data_done", {31'd0, done}, 32'd1);
    chk("start_data_writes", 32'(wr_count - wr_base), 32'd3);
    chk("start_data_w1", mem[1], 32'hFEED_F00D);
    chk("start_data_w2", mem[2], 32'h0BAD_CAFE);
    chk("start_data_adr", wb.adr, 32'h0000_000C);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
